// File: rtl/lut_ram_multiport.sv
// Multi-read-port LUT RAM: combinational reads, byte-enabled synchronous writes,
// optional write-to-read bypass and a post-reset clear sequencer.
module lut_ram_multiport #(
    parameter int LUT_WIDTH      = 32,
    parameter int LUT_DEPTH      = 256,
    parameter int NUM_RD_PORTS   = 2,
    parameter int BYPASS         = 0,
    parameter int CLEAR_ON_RESET = 1,
    localparam int ADDR_W        = (LUT_DEPTH > 1) ? $clog2(LUT_DEPTH) : 1,
    localparam int BE_W          = LUT_WIDTH / 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             wr_en,
    input  logic [ADDR_W-1:0]                wr_addr,
    input  logic [BE_W-1:0]                  wr_be,
    input  logic [LUT_WIDTH-1:0]             wr_data,
    input  logic [NUM_RD_PORTS*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD_PORTS*LUT_WIDTH-1:0] rd_data,
    output logic                             init_busy
);

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } state_t;

    localparam state_t            RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(LUT_DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LUT_DEPTH - 1);

    logic [LUT_WIDTH-1:0] mem [LUT_DEPTH];

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic              init_busy_q, init_busy_d;
    logic              clr_we;
    logic              wr_ok;

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        clr_we     = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                clr_we     = !rst;
                clr_addr_d = clr_addr_q + ADDR_W'(1);
                if (clr_addr_q == LAST_ADDR) begin
                    state_d    = ST_READY;
                    clr_addr_d = '0;
                end
            end
            default: ;
        endcase
        init_busy_d = (state_d == ST_CLEAR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RST_STATE;
            clr_addr_q  <= '0;
            init_busy_q <= (RST_STATE == ST_CLEAR);
        end else begin
            state_q     <= state_d;
            clr_addr_q  <= clr_addr_d;
            init_busy_q <= init_busy_d;
        end
    end

    assign init_busy = init_busy_q;

    // A write is only real when it will actually land; bypass keys off the same term.
    assign wr_ok = wr_en && !rst && (state_q == ST_READY) && ({1'b0, wr_addr} < DEPTH_EXT);

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr_q] <= '0;
        end else if (wr_ok) begin
            for (int b = 0; b < BE_W; b++) begin
                if (wr_be[b]) begin
                    mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_RD_PORTS; gi++) begin : g_rd
            logic [ADDR_W-1:0]    ra;
            logic [LUT_WIDTH-1:0] stored;
            logic [LUT_WIDTH-1:0] merged;
            logic [LUT_WIDTH-1:0] port_data;
            logic                 in_range;
            logic                 hit;

            assign ra = rd_addr[gi*ADDR_W +: ADDR_W];

            always_comb begin
                in_range = ({1'b0, ra} < DEPTH_EXT);
                stored   = in_range ? mem[ra] : '0;
                hit      = (BYPASS != 0) && wr_ok && (ra == wr_addr);
                merged   = stored;
                for (int b = 0; b < BE_W; b++) begin
                    if (wr_be[b]) begin
                        merged[8*b +: 8] = wr_data[8*b +: 8];
                    end
                end
                if (init_busy_q) begin
                    port_data = '0;
                end else if (hit) begin
                    port_data = merged;
                end else begin
                    port_data = stored;
                end
            end

            assign rd_data[gi*LUT_WIDTH +: LUT_WIDTH] = port_data;
        end
    endgenerate

endmodule

// File: tb/tb_lut_ram_multiport.sv
// Bench for lut_ram_multiport: one bypassing 256-entry instance and one
// non-bypassing 200-entry instance share stimulus and are checked against a model.
module tb_lut_ram_multiport;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [7:0]  wr_addr = '0;
    logic [3:0]  wr_be = '0;
    logic [31:0] wr_data = '0;
    logic [15:0] rd_addr = '0;
    logic [63:0] rd_data_a, rd_data_b;
    logic        busy_a, busy_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lut_ram_multiport #(.LUT_WIDTH(32), .LUT_DEPTH(256), .NUM_RD_PORTS(2),
                        .BYPASS(1), .CLEAR_ON_RESET(1)) dut_a (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
        .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data_a), .init_busy(busy_a));

    lut_ram_multiport #(.LUT_WIDTH(32), .LUT_DEPTH(200), .NUM_RD_PORTS(2),
                        .BYPASS(0), .CLEAR_ON_RESET(1)) dut_b (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
        .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data_b), .init_busy(busy_b));

    // Model: index 0 mirrors dut_a, index 1 mirrors dut_b.
    logic [31:0] mdl_mem [2][256];
    int          mdl_cnt [2];
    bit          mdl_valid = 1'b0;

    function automatic int depth_of(input int d);
        return (d == 0) ? 256 : 200;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] exp_rd(input int d, input logic [7:0] a);
        if (mdl_cnt[d] > 0) return 32'h0;
        if (int'(a) >= depth_of(d)) return 32'h0;
        if (d == 0 && wr_en && !rst && a == wr_addr) return merge(mdl_mem[d][a], wr_data, wr_be);
        return mdl_mem[d][a];
    endfunction

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                mdl_cnt[d] = depth_of(d);
            end else if (mdl_cnt[d] > 0) begin
                mdl_mem[d][depth_of(d) - mdl_cnt[d]] = 32'h0;
                mdl_cnt[d]--;
            end else if (wr_en && int'(wr_addr) < depth_of(d)) begin
                mdl_mem[d][wr_addr] = merge(mdl_mem[d][wr_addr], wr_data, wr_be);
            end
        end
        if (rst) mdl_valid = 1'b1;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mdl_valid) begin
            for (int p = 0; p < 2; p++) begin
                check($sformatf("model_rd a p%0d addr%0d", p, rd_addr[p*8 +: 8]),
                      rd_data_a[p*32 +: 32], exp_rd(0, rd_addr[p*8 +: 8]));
                check($sformatf("model_rd b p%0d addr%0d", p, rd_addr[p*8 +: 8]),
                      rd_data_b[p*32 +: 32], exp_rd(1, rd_addr[p*8 +: 8]));
            end
            check("model_busy a", {31'h0, busy_a}, {31'h0, mdl_cnt[0] > 0});
            check("model_busy b", {31'h0, busy_b}, {31'h0, mdl_cnt[1] > 0});
        end
    end

    task automatic cyc(input logic r, input logic en, input logic [7:0] a, input logic [3:0] be,
                       input logic [31:0] dat, input logic [7:0] r0, input logic [7:0] r1);
        @(posedge clk);
        #1;
        rst = r; wr_en = en; wr_addr = a; wr_be = be; wr_data = dat; rd_addr = {r1, r0};
        @(negedge clk);
    endtask

    task automatic run_clear(input int cycles, output int cnt_a, output int cnt_b);
        cnt_a = 0;
        cnt_b = 0;
        for (int n = 0; n < cycles; n++) begin
            cnt_a += int'(busy_a);
            cnt_b += int'(busy_b);
            if (n == 5)        cyc(1'b0, 1'b1, 8'd5, 4'hF, 32'hDEADBEEF, 8'd0, 8'd128);
            else if (n == 210) cyc(1'b0, 1'b1, 8'd6, 4'hF, 32'h12345678, 8'd0, 8'd255);
            else               cyc(1'b0, 1'b0, 8'd0, 4'h0, 32'h0, 8'd0, n[0] ? 8'd255 : 8'd128);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int ca, cb;
        logic [7:0] a, r0, r1;

        cyc(1'b1, 1'b1, 8'd20, 4'hF, 32'hDEADBEEF, 8'd0, 8'd0);
        cyc(1'b1, 1'b0, 8'd0, 4'h0, 32'h0, 8'd0, 8'd0);
        check("reset busy a", {31'h0, busy_a}, 32'd1);
        check("reset busy b", {31'h0, busy_b}, 32'd1);

        cyc(1'b0, 1'b0, 8'd0, 4'h0, 32'h0, 8'd0, 8'd128);
        run_clear(300, ca, cb);
        check("clear length a", ca, 32'd256);
        check("clear length b", cb, 32'd200);

        cyc(1'b0, 1'b0, 8'd0, 4'h0, 32'h0, 8'd5, 8'd6);
        check("busy drop a addr5", rd_data_a[31:0], 32'h0);
        check("busy drop a addr6", rd_data_a[63:32], 32'h0);
        check("busy drop b addr5", rd_data_b[31:0], 32'h0);
        check("ready write b addr6", rd_data_b[63:32], 32'h12345678);

        cyc(1'b0, 1'b1, 8'd10, 4'hF, 32'h11223344, 8'd10, 8'd10);
        cyc(1'b0, 1'b1, 8'd10, 4'h5, 32'hAABBCCDD, 8'd10, 8'd10);
        check("byte en bypass a", rd_data_a[31:0], 32'h11BB33DD);
        check("byte en old b", rd_data_b[31:0], 32'h11223344);
        cyc(1'b0, 1'b0, 8'd0, 4'h0, 32'h0, 8'd10, 8'd10);
        check("byte en a addr10", rd_data_a[31:0], 32'h11BB33DD);
        check("byte en b addr10", rd_data_b[31:0], 32'h11BB33DD);

        cyc(1'b0, 1'b1, 8'd3, 4'hC, 32'hCAFEF00D, 8'd3, 8'd3);
        check("bypass a p1 before edge", rd_data_a[63:32], 32'hCAFE0000);
        check("no bypass b p1 before edge", rd_data_b[63:32], 32'h0);
        cyc(1'b0, 1'b0, 8'd0, 4'h0, 32'h0, 8'd3, 8'd3);
        check("bypass a p1 after edge", rd_data_a[63:32], 32'hCAFE0000);
        check("no bypass b p1 after edge", rd_data_b[63:32], 32'hCAFE0000);

        cyc(1'b0, 1'b1, 8'd7, 4'hF, 32'h00000055, 8'd0, 8'd0);
        cyc(1'b0, 1'b0, 8'd0, 4'h0, 32'h0, 8'd7, 8'd7);
        check("multiport b p0 addr7", rd_data_b[31:0], 32'h55);
        check("multiport b p1 addr7", rd_data_b[63:32], 32'h55);
        cyc(1'b0, 1'b1, 8'd250, 4'hF, 32'hFFFFFFFF, 8'd7, 8'd250);
        check("range b p1 addr250", rd_data_b[63:32], 32'h0);
        check("bypass a p1 addr250", rd_data_a[63:32], 32'hFFFFFFFF);
        cyc(1'b0, 1'b0, 8'd0, 4'h0, 32'h0, 8'd7, 8'd250);
        check("range b addr7 kept", rd_data_b[31:0], 32'h55);
        check("range b addr250 zero", rd_data_b[63:32], 32'h0);
        check("a addr250 stored", rd_data_a[63:32], 32'hFFFFFFFF);
        for (int i = 0; i < 256; i += 2) cyc(1'b0, 1'b0, 8'd0, 4'h0, 32'h0, 8'(i), 8'(i + 1));

        cyc(1'b1, 1'b0, 8'd0, 4'h0, 32'h0, 8'd0, 8'd0);
        cyc(1'b1, 1'b0, 8'd0, 4'h0, 32'h0, 8'd0, 8'd0);
        cyc(1'b0, 1'b0, 8'd0, 4'h0, 32'h0, 8'd3, 8'd10);
        for (int n = 0; n < 99; n++) cyc(1'b0, 1'b0, 8'd0, 4'h0, 32'h0, 8'd3, 8'd10);
        cyc(1'b1, 1'b1, 8'd9, 4'hF, 32'h0BADF00D, 8'd3, 8'd10);
        cyc(1'b0, 1'b0, 8'd0, 4'h0, 32'h0, 8'd3, 8'd10);
        run_clear(300, ca, cb);
        check("mid-clear length a", ca, 32'd256);
        check("mid-clear length b", cb, 32'd200);
        cyc(1'b0, 1'b0, 8'd0, 4'h0, 32'h0, 8'd9, 8'd250);
        check("mid-clear a addr9", rd_data_a[31:0], 32'h0);
        check("mid-clear a addr250", rd_data_a[63:32], 32'h0);

        for (int k = 0; k < 1000; k++) begin
            a  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
            r0 = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
            r1 = ($urandom_range(0, 1) == 0) ? a : 8'($urandom_range(0, 15));
            cyc(1'b0, 1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom, r0, r1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
